alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered, handshaked operand-selection stage between decode and the ALU, generalising the combinational ALU source muxes. It resolves `rs1`/`rs2` through a parametrised set of prioritised forwarding sources, interlocks on unresolved (load-use) hazards, and selects PC/zero/immediate sources per instruction. Operands are presented to execute one cycle after acceptance. It sits at the ID/EX boundary and drives `alu_src_a_o`, `alu_src_b_o` and the forwarded store/branch operand.

## Interface
- `ADDR_WIDTH`, 32: PC width.
- `DATA_WIDTH`, 32: operand/register width.
- `NUM_FWD`, 2: number of forwarding sources; index 0 = youngest, highest priority.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  **asynchronous, active-high reset**.
- `flush_i`  in  1  kill the held instruction.
- `valid_i` / `ready_o`  in/out  1  upstream handshake.
- `pc_i`  in  ADDR_WIDTH  instruction PC.
- `opcode_i`  in  rv32i_base_instr  decoded opcode.
- `instr_type_i`  in  rv32i_base_instr_type  R/I/S/B/U/J.
- `rs1_addr_i`, `rs2_addr_i`  in  5  source register indices.
- `rs1_data_i`, `rs2_data_i`  in  DATA_WIDTH  register-file read data.
- `imm_value_i`  in  DATA_WIDTH  sign-extended immediate.
- `fwd_valid_i`  in  NUM_FWD  source i holds a register-writing instruction.
- `fwd_pending_i`  in  NUM_FWD  source i result not yet available (load in flight).
- `fwd_rd_addr_i`  in  NUM_FWD×5  destination of source i.
- `fwd_data_i`  in  NUM_FWD×DATA_WIDTH  result of source i.
- `valid_o` / `ready_i`  out/in  1  downstream handshake.
- `alu_src_a_o`, `alu_src_b_o`  out  DATA_WIDTH  ALU operands.
- `rs2_fwd_o`  out  DATA_WIDTH  resolved rs2 (store data / branch compare).
- `stall_cnt_o`  out  16  saturating count of hazard-stall cycles.

## Operation
- Usage: rs1 used for R, I, S, B; rs2 used for R, S, B. Unused or x0 operands never hazard and never forward (x0 reads as 0).
- Resolution per used operand: lowest index i with `fwd_valid_i[i]` and `fwd_rd_addr_i[i]==addr` wins. If `fwd_pending_i[i]` → hazard; else value = `fwd_data_i[i]`. No match → register-file data.
- `hazard` = any used operand hazarded. `ready_o = !hazard && !flush_i && (!valid_o || ready_i)`.
- Source A: AUIPC, JAL → `pc_i`; LUI → 0; else resolved rs1.
- Source B: type I, S, U, J → `imm_value_i`; else resolved rs2. `rs2_fwd_o` always resolved rs2.
- Accept (`valid_i && ready_o`): register all outputs, `valid_o`=1. Output drained (`valid_o && ready_i`) with no accept: `valid_o`=0. Drain and accept same cycle: new data replaces old, `valid_o` stays 1.
- Output data held stable while `valid_o && !ready_i`.
- `flush_i`: `valid_o`=0 next cycle, no accept that cycle; overrides drain/accept.
- `stall_cnt_o` increments on cycles with `valid_i && hazard`; saturates at 0xFFFF.

## Timing
- Reset (async assert, sync-released use): `valid_o`=0, `alu_src_a_o`=`alu_src_b_o`=`rs2_fwd_o`=0, `stall_cnt_o`=0.
- Latency 1 cycle accept→`valid_o`; throughput 1/cycle with `ready_i`=1.
- `ready_o` combinational from inputs and `valid_o`; all other outputs registered.
- Hazard stall lasts until the matching source clears `fwd_pending_i` or retires; operand sampled on the accepting edge.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding as above.
- Not defined: no data forwarding; any valid match on a used operand (pending or not) is a hazard; operands always come from `rs*_data_i`. `fwd_data_i` unused; `stall_cnt_o` counts these interlocks.

## Test plan
- ADD x3,x1,x2, rs1=5, rs2=7, no fwd → next cycle `valid_o`=1, A=5, B=7.
- AUIPC pc=0x100, imm=0x1000 → A=0x100, B=0x1000; LUI → A=0, B=imm.
- rs1=x4, fwd[0] and fwd[1] both rd=x4 (data 0xAA/0xBB), not pending → A=0xAA (macro on); macro off → stall until both clear.
- rs2=x5, fwd[1] pending rd=x5 for 3 cycles → `ready_o`=0 3 cycles, `stall_cnt_o`=3, then B=fwd_data_i[1]; rs2=x0 with fwd rd=x0 → no stall, B=0.
- `ready_i`=0 with `valid_o`=1 → outputs stable, `ready_o`=0; `flush_i` pulse → `valid_o`=0 next cycle; async `rst_i` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand selection with prioritised forwarding and load-use interlock; define ALU_OPERAND_FWD_EN to enable data forwarding
package alu_operand_stage_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } rv32i_base_instr_type;

endpackage

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [ADDR_WIDTH-1:0]         pc_i,
    input  rv32i_base_instr               opcode_i,
    input  rv32i_base_instr_type          instr_type_i,
    input  logic [4:0]                    rs1_addr_i,
    input  logic [4:0]                    rs2_addr_i,
    input  logic [DATA_WIDTH-1:0]         rs1_data_i,
    input  logic [DATA_WIDTH-1:0]         rs2_data_i,
    input  logic [DATA_WIDTH-1:0]         imm_value_i,
    input  logic [NUM_FWD-1:0]            fwd_valid_i,
    input  logic [NUM_FWD-1:0]            fwd_pending_i,
    input  logic [NUM_FWD*5-1:0]          fwd_rd_addr_i,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         alu_src_a_o,
    output logic [DATA_WIDTH-1:0]         alu_src_b_o,
    output logic [DATA_WIDTH-1:0]         rs2_fwd_o,
    output logic [15:0]                   stall_cnt_o
);

    logic                  rs1_used, rs2_used;
    logic                  rs1_haz, rs2_haz, hazard;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
    logic [DATA_WIDTH-1:0] src_a, src_b;
    logic                  accept;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0] src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0] rs2_fwd_q, rs2_fwd_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

`ifndef ALU_OPERAND_FWD_EN
    // Without forwarding only the match itself matters, never the data or pending state
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data_i, fwd_pending_i};
`endif

    // Resolve each used operand; scanning from the oldest source down lets index 0 win
    always_comb begin
        rs1_used = (instr_type_i == R_TYPE) || (instr_type_i == I_TYPE) ||
                   (instr_type_i == S_TYPE) || (instr_type_i == B_TYPE);
        rs2_used = (instr_type_i == R_TYPE) || (instr_type_i == S_TYPE) ||
                   (instr_type_i == B_TYPE);
        rs1_val  = (rs1_addr_i == 5'd0) ? '0 : rs1_data_i;
        rs2_val  = (rs2_addr_i == 5'd0) ? '0 : rs2_data_i;
        rs1_haz  = 1'b0;
        rs2_haz  = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (rs1_used && (rs1_addr_i != 5'd0) && fwd_valid_i[i] &&
                (fwd_rd_addr_i[i*5 +: 5] == rs1_addr_i)) begin
`ifdef ALU_OPERAND_FWD_EN
                rs1_haz = fwd_pending_i[i];
                rs1_val = fwd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
`else
                rs1_haz = 1'b1;
`endif
            end
            if (rs2_used && (rs2_addr_i != 5'd0) && fwd_valid_i[i] &&
                (fwd_rd_addr_i[i*5 +: 5] == rs2_addr_i)) begin
`ifdef ALU_OPERAND_FWD_EN
                rs2_haz = fwd_pending_i[i];
                rs2_val = fwd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
`else
                rs2_haz = 1'b1;
`endif
            end
        end
        hazard = rs1_haz || rs2_haz;
    end

    // Pick ALU sources: PC for AUIPC/JAL, zero for LUI, immediate for non-R/B formats
    always_comb begin
        case (opcode_i)
            AUIPC, JAL: src_a = DATA_WIDTH'(pc_i);
            LUI:        src_a = '0;
            default:    src_a = rs1_val;
        endcase
        case (instr_type_i)
            I_TYPE, S_TYPE, U_TYPE, J_TYPE: src_b = imm_value_i;
            default:                        src_b = rs2_val;
        endcase
    end

    assign ready_o = !hazard && !flush_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    // Next state: flush beats accept, accept beats drain; stall counter saturates
    always_comb begin
        valid_d     = valid_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        rs2_fwd_d   = rs2_fwd_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            src_a_d   = src_a;
            src_b_d   = src_b;
            rs2_fwd_d = rs2_val;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (valid_i && hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Output register stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            rs2_fwd_q   <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            rs2_fwd_q   <= rs2_fwd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign alu_src_a_o = src_a_q;
    assign alu_src_b_o = src_b_q;
    assign rs2_fwd_o   = rs2_fwd_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 flush_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [31:0]          pc_i;
    rv32i_base_instr      opcode_i;
    rv32i_base_instr_type instr_type_i;
    logic [4:0]           rs1_addr_i, rs2_addr_i;
    logic [31:0]          rs1_data_i, rs2_data_i, imm_value_i;
    logic [1:0]           fwd_valid_i, fwd_pending_i;
    logic [9:0]           fwd_rd_addr_i;
    logic [63:0]          fwd_data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [31:0]          alu_src_a_o, alu_src_b_o, rs2_fwd_o;
    logic [15:0]          stall_cnt_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [95:0] exp_q[$];

    alu_operand_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_FWD(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .opcode_i(opcode_i), .instr_type_i(instr_type_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_value_i(imm_value_i), .fwd_valid_i(fwd_valid_i),
        .fwd_pending_i(fwd_pending_i), .fwd_rd_addr_i(fwd_rd_addr_i),
        .fwd_data_i(fwd_data_i), .valid_o(valid_o), .ready_i(ready_i),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .rs2_fwd_o(rs2_fwd_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor: a transfer is compared against the scoreboard head; a flushed item is dropped
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (flush_i) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got a=%h b=%h r=%h exp=none", alu_src_a_o, alu_src_b_o, rs2_fwd_o);
                end else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    if ({alu_src_a_o, alu_src_b_o, rs2_fwd_o} !== e)
                        begin errors++;
                        $display("FAIL operands got a=%h b=%h r=%h exp a=%h b=%h r=%h",
                                 alu_src_a_o, alu_src_b_o, rs2_fwd_o, e[95:64], e[63:32], e[31:0]); end
                end
            end
        end
    end

    task automatic set_instr(input rv32i_base_instr op, input rv32i_base_instr_type ty,
                             input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        opcode_i = op; instr_type_i = ty; pc_i = pc;
        rs1_addr_i = a1; rs2_addr_i = a2; rs1_data_i = d1; rs2_data_i = d2; imm_value_i = imm;
    endtask

    task automatic set_fwd(input logic [1:0] v, input logic [1:0] p, input logic [4:0] rd0,
                           input logic [4:0] rd1, input logic [31:0] fd0, input logic [31:0] fd1);
        fwd_valid_i = v; fwd_pending_i = p; fwd_rd_addr_i = {rd1, rd0}; fwd_data_i = {fd1, fd0};
    endtask

    // Present the current instruction until accepted, pushing the expectation on the accepting edge
    task automatic send(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] er);
        logic acc;
        acc = 1'b0;
        valid_i = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                exp_q.push_back({ea, eb, er});
                acc = 1'b1;
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL send_timeout got=not_accepted exp=accepted"); end
    endtask

    task automatic idle(input int n);
        ready_i = 1'b1;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if ({alu_src_a_o, alu_src_b_o, rs2_fwd_o} !== 96'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {alu_src_a_o, alu_src_b_o, rs2_fwd_o}); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall got=%h exp=0", stall_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_add;
        set_instr(ADD, R_TYPE, 32'h0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0);
        send(32'd5, 32'd7, 32'd7);
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_latency got=%b exp=1", valid_o); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cyc;
        set_instr(AUIPC, U_TYPE, 32'h100, 5'd0, 5'd7, 32'h0, 32'h33, 32'h1000);
        send(32'h100, 32'h1000, 32'h33);
        set_instr(LUI, U_TYPE, 32'h104, 5'd9, 5'd0, 32'h44, 32'h0, 32'hABCD_0000);
        send(32'h0, 32'hABCD_0000, 32'h0);
        set_instr(JAL, J_TYPE, 32'h200, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8);
        send(32'h200, 32'h8, 32'h0);
        set_instr(ADDI, I_TYPE, 32'h204, 5'd0, 5'd0, 32'h55, 32'h0, 32'd3);
        send(32'h0, 32'd3, 32'h0);
        checks++; if (cyc - c0 != 4) begin errors++; $display("FAIL throughput got=%0d exp=4", cyc - c0); end
        idle(2);
    endtask

    task automatic test_fwd_priority;
        set_instr(ADD, R_TYPE, 32'h0, 5'd4, 5'd6, 32'h11, 32'h22, 32'h0);
        set_fwd(2'b11, 2'b00, 5'd4, 5'd4, 32'hAA, 32'hBB);
`ifdef ALU_OPERAND_FWD_EN
        send(32'hAA, 32'h22, 32'h22);
        set_fwd(2'b11, 2'b00, 5'd7, 5'd4, 32'hAA, 32'hBB);
        send(32'hBB, 32'h22, 32'h22);
`else
        valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", ready_o); end
            @(posedge clk_i); #1;
            if (c == 1) fwd_valid_i[0] = 1'b0;
        end
        fwd_valid_i[1] = 1'b0;
        exp_stall = exp_stall + 16'd4;
        send(32'h11, 32'h22, 32'h22);
`endif
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL prio_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        idle(2);
    endtask

    task automatic test_load_use;
        set_instr(ADD, R_TYPE, 32'h0, 5'd1, 5'd5, 32'h10, 32'h50, 32'h0);
        set_fwd(2'b11, 2'b10, 5'd9, 5'd5, 32'h99, 32'h77);
        valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL load_use_ready got=%b exp=0", ready_o); end
            @(posedge clk_i); #1;
        end
        exp_stall = exp_stall + 16'd3;
`ifdef ALU_OPERAND_FWD_EN
        fwd_pending_i = 2'b00;
        send(32'h10, 32'h77, 32'h77);
`else
        fwd_valid_i[1] = 1'b0;
        send(32'h10, 32'h50, 32'h50);
`endif
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        @(posedge clk_i); #1;
        set_fwd(2'b11, 2'b11, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF);
        set_instr(ADD, R_TYPE, 32'h0, 5'd0, 5'd0, 32'h12, 32'h34, 32'h0);
        send(32'h0, 32'h0, 32'h0);
        set_fwd(2'b10, 2'b10, 5'd0, 5'd5, 32'h0, 32'h77);
        set_instr(ADDI, I_TYPE, 32'h0, 5'd3, 5'd5, 32'h30, 32'h50, 32'h9);
        send(32'h30, 32'h9, 32'h50);
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL x0_unused_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        idle(2);
    endtask

    task automatic test_backpressure;
        ready_i = 1'b0;
        set_instr(SUB, R_TYPE, 32'h0, 5'd1, 5'd2, 32'd20, 32'd8, 32'h0);
        send(32'd20, 32'd8, 32'd8);
        set_instr(XOR, R_TYPE, 32'h0, 5'd1, 5'd2, 32'hF0, 32'h0F, 32'h0);
        valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", ready_o); end
            checks++; if ({valid_o, alu_src_a_o, alu_src_b_o} !== {1'b1, 32'd20, 32'd8})
                begin errors++; $display("FAIL bp_hold got=%b/%h/%h exp=1/14/8", valid_o, alu_src_a_o, alu_src_b_o); end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        send(32'hF0, 32'h0F, 32'h0F);
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_drain_accept got=%b exp=1", valid_o); end
        idle(2);
    endtask

    task automatic test_flush;
        ready_i = 1'b0;
        set_instr(AND, R_TYPE, 32'h0, 5'd1, 5'd2, 32'hFF, 32'h0F, 32'h0);
        send(32'hFF, 32'h0F, 32'h0F);
        flush_i = 1'b1;
        valid_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", ready_o); end
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
        idle(2);
    endtask

    task automatic test_async_reset;
        ready_i = 1'b0;
        set_instr(OR, R_TYPE, 32'h0, 5'd1, 5'd2, 32'h123, 32'h456, 32'h0);
        send(32'h123, 32'h456, 32'h456);
        @(negedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", valid_o); end
        checks++; if ({alu_src_a_o, alu_src_b_o, rs2_fwd_o, stall_cnt_o} !== 112'd0)
            begin errors++; $display("FAIL async_rst_data got=%h exp=0", {alu_src_a_o, alu_src_b_o, rs2_fwd_o, stall_cnt_o}); end
        exp_q.delete();
        exp_stall = 16'd0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ready_i = 1'b1;
        set_instr(ADD, R_TYPE, 32'h0, 5'd1, 5'd2, 32'd100, 32'd200, 32'h0);
        send(32'd100, 32'd200, 32'd200);
        idle(2);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        set_instr(ADD, R_TYPE, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_fwd_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_async_reset();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
